ram32x4_arbiter: RTL and testbench
==================================

Name: ram32x4_arbiter

Overview:
- Controller sitting between two requesters and a single-port 32x4 synchronous RAM. Sequences all RAM accesses.
- Arbitrates word-wide read/write requests round-robin.
- Runs a clear sequencer that writes FILL_VALUE to all 32 words after reset, or on command.
- The RAM registers address/data/wren on the rising clock and has unregistered output, so read data appears on ram_q in the cycle after the access edge.

Parameters:
- FILL_VALUE, 4'h0, value written to every word by the clear sequencer.
- CLEAR_ON_RESET, 1, when 1 a clear sequence starts automatically on leaving reset; when 0 the block starts in IDLE.

Ports:
- clock  in  1  single system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- clear  in  1  one-cycle request to start the clear sequence.
- busy  out  1  high while the clear sequence runs.
- req0 / req1  in  1  access request from requester 0 / 1.
- we0 / we1  in  1  1 = write, 0 = read, for requester 0 / 1.
- addr0 / addr1  in  5  word address for requester 0 / 1.
- wdata0 / wdata1  in  4  write data for requester 0 / 1.
- gnt0 / gnt1  out  1  combinational grant; the access occurs at the clock edge where gnt is high.
- rvalid0 / rvalid1  out  1  registered; high for one cycle when rdata holds a read result for that requester.
- rdata  out  4  read data, passed through from ram_q.
- ram_address  out  5  to RAM address.
- ram_data  out  4  to RAM data.
- ram_wren  out  1  to RAM wren.
- ram_q  in  4  from RAM q.
- conflict_cnt  out  8  contention counter (see Optional Feature).

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (reset high at an edge):
  - State <= CLEAR if CLEAR_ON_RESET else IDLE; clear counter <= 0.
  - Round-robin pointer prio <= 0; rvalid0/1 <= 0; conflict_cnt <= 0.
  - While reset is held high, gnt0/gnt1 = 0 and ram_wren = 0.
- State CLEAR:
  - ram_address = cnt, ram_data = FILL_VALUE, ram_wren = 1, busy = 1, gnt0 = gnt1 = 0.
  - cnt increments each cycle. At the edge where cnt == 31, state <= IDLE and cnt <= 0.
  - Exactly 32 writes; busy is high for 32 cycles.
  - clear asserted during CLEAR is ignored (no restart).
- State IDLE:
  - busy = 0.
  - If clear = 1, it takes priority: state <= CLEAR, no grant that cycle, ram_wren = 0. The first clear write occurs in the following cycle.
  - Otherwise, if only reqN is high: gntN = 1.
  - If both req0 and req1 are high: gnt goes to the requester indexed by prio; at that edge prio <= index of the loser.
  - A single-requester grant also sets prio <= the other index.
  - No request: ram_wren = 0, ram_address = 0, ram_data = 0.
- Granted access:
  - ram_address = addrN, ram_data = wdataN, ram_wren = weN.
  - For a read (weN = 0), rvalidN <= 1 at that edge, so rvalidN is high for the next cycle with rdata = ram_q.
  - Writes produce no rvalid.
- Requester rules:
  - A requester holds req/we/addr/wdata stable until it samples gnt high.
  - It may drop req or issue a new request in the cycle after the grant.
  - A lone requester can be granted every cycle (throughput 1 access/cycle).
- Other rules:
  - rvalid0 and rvalid1 are never high together.
  - A read of an address written in the previous cycle returns the new data.
  - Reset in mid-clear or with a read outstanding: state and rvalid restart per reset values; the partial clear is not resumed, and a new clear starts if CLEAR_ON_RESET = 1.
  - State encoding has 2 states; unused encodings go to IDLE.

Optional Feature:
- Macro: RAM32X4_ARB_STATS_EN.
- Defined: conflict_cnt increments by 1 at every IDLE edge where req0 and req1 are both high and clear = 0. It saturates at 8'hFF and is cleared only by reset.
- Undefined: conflict_cnt is tied to 8'h00; no counter logic is synthesized.

Test Plan:
- Reset with CLEAR_ON_RESET=1, FILL_VALUE=4'h5, then release reset -> busy high exactly 32 cycles; ram_wren=1 with ram_address 0..31, ram_data 5; after that, a read of addr 17 via req0 returns rdata=5 with rvalid0 one cycle after gnt0.
- req0 write addr 3 data 4'hA; next cycle req1 read addr 3 -> gnt0, then gnt1; rvalid1 high the following cycle with rdata=4'hA; rvalid0 never high.
- req0 and req1 held high together for 6 cycles after reset (prio=0) -> grants alternate 0,1,0,1,0,1; with STATS_EN defined, conflict_cnt=6.
- req1 alone, reads of addr 0..3 back-to-back -> gnt1 high 4 consecutive cycles; rvalid1 high 4 consecutive cycles, one cycle delayed, data in order.
- In IDLE, assert clear together with req0 -> no grant that cycle; busy high next 32 cycles with gnt0=0 throughout; req0 granted on the first cycle after busy falls.
- Assert reset at clear cycle 10, CLEAR_ON_RESET=0 -> outputs at reset values; state IDLE; addr 20 reads back its pre-clear contents, addr 5 reads FILL_VALUE.

Source files
------------

// File: rtl/ram32x4_arbiter.sv
// Round-robin arbiter and clear sequencer in front of a single-port 32x4 synchronous RAM.
// Define RAM32X4_ARB_STATS_EN to build the saturating contention counter on conflict_cnt.
module ram32x4_arbiter #(
    parameter logic [3:0] FILL_VALUE     = 4'h0,
    parameter bit         CLEAR_ON_RESET = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    output logic       busy,
    input  logic       req0,
    input  logic       req1,
    input  logic       we0,
    input  logic       we1,
    input  logic [4:0] addr0,
    input  logic [4:0] addr1,
    input  logic [3:0] wdata0,
    input  logic [3:0] wdata1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       rvalid0,
    output logic       rvalid1,
    output logic [3:0] rdata,
    output logic [4:0] ram_address,
    output logic [3:0] ram_data,
    output logic       ram_wren,
    input  logic [3:0] ram_q,
    output logic [7:0] conflict_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b01,
        ST_CLEAR = 2'b10
    } state_t;

    localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

    state_t     state;
    logic [4:0] cnt;
    logic       prio;
    logic       clearing;
    logic       idle;
    logic       arb_en;

    // Reset masks every RAM-facing and grant output while it is held.
    assign clearing = !reset && (state == ST_CLEAR);
    assign idle     = !reset && (state == ST_IDLE);
    assign arb_en   = idle && !clear;

    assign busy  = clearing;
    assign gnt0  = arb_en && req0 && (!req1 || !prio);
    assign gnt1  = arb_en && req1 && (!req0 || prio);
    assign rdata = ram_q;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        ram_address = '0;
        ram_data    = '0;
        ram_wren    = 1'b0;
        if (clearing) begin
            ram_address = cnt;
            ram_data    = FILL_VALUE;
            ram_wren    = 1'b1;
        end else if (gnt0) begin
            ram_address = addr0;
            ram_data    = wdata0;
            ram_wren    = we0;
        end else if (gnt1) begin
            ram_address = addr1;
            ram_data    = wdata1;
            ram_wren    = we1;
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state   <= RESET_STATE;
            cnt     <= '0;
            prio    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            rvalid0 <= gnt0 && !we0;
            rvalid1 <= gnt1 && !we1;
            // The loser of this edge (or the idle side of a lone grant) wins the next tie.
            if (gnt0) begin
                prio <= 1'b1;
            end else if (gnt1) begin
                prio <= 1'b0;
            end
            case (state)
                ST_CLEAR: begin
                    if (cnt == 5'd31) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                ST_IDLE: begin
                    if (clear) begin
                        state <= ST_CLEAR;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef RAM32X4_ARB_STATS_EN
    logic [7:0] conflict_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            conflict_q <= '0;
        end else if (state == ST_IDLE && req0 && req1 && !clear && conflict_q != 8'hFF) begin
            conflict_q <= conflict_q + 8'd1;
        end
    end

    assign conflict_cnt = conflict_q;
`else
    assign conflict_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_ram32x4_arbiter.sv
// Self-checking bench: two arbiter instances (auto-clear and idle start) each with a behavioural RAM,
// compared against a round-robin / memory-image reference model under directed and random traffic.
module tb_ram32x4_arbiter;

    localparam logic [3:0] FILL = 4'h5;
    localparam logic [7:0] EXP_CONTENTION =
`ifdef RAM32X4_ARB_STATS_EN
        8'd6;
`else
        8'd0;
`endif

    logic       clock   = 1'b0;
    logic       reset_a = 1'b1;
    logic       reset_b = 1'b1;
    logic       clear   = 1'b0;
    logic       req0    = 1'b0;
    logic       req1    = 1'b0;
    logic       we0     = 1'b0;
    logic       we1     = 1'b0;
    logic [4:0] addr0   = '0;
    logic [4:0] addr1   = '0;
    logic [3:0] wdata0  = '0;
    logic [3:0] wdata1  = '0;

    logic       busy_a, gnt0_a, gnt1_a, rvalid0_a, rvalid1_a, ram_wren_a;
    logic [3:0] rdata_a, ram_data_a, ram_q_a;
    logic [4:0] ram_address_a;
    logic [7:0] conflict_cnt_a;
    logic       busy_b, gnt0_b, gnt1_b, rvalid0_b, rvalid1_b, ram_wren_b;
    logic [3:0] rdata_b, ram_data_b, ram_q_b;
    logic [4:0] ram_address_b;
    logic [7:0] conflict_cnt_b;

    int checks   = 0;
    int failures = 0;

    // Reference model: memory image, tie-break preference, expected read return
    logic [3:0] ref_mem [32];
    logic       rr_pref;
    int         ref_conf;
    logic [1:0] exp_rv;
    logic [3:0] exp_rd;
    logic [1:0] exp_g;

    always #5 clock = ~clock;

    ram32x4_arbiter #(.FILL_VALUE(FILL), .CLEAR_ON_RESET(1'b1)) u_dut_a (
        .clock(clock), .reset(reset_a), .clear(clear), .busy(busy_a),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0_a), .gnt1(gnt1_a), .rvalid0(rvalid0_a), .rvalid1(rvalid1_a),
        .rdata(rdata_a), .ram_address(ram_address_a), .ram_data(ram_data_a),
        .ram_wren(ram_wren_a), .ram_q(ram_q_a), .conflict_cnt(conflict_cnt_a)
    );

    ram32x4_arbiter #(.FILL_VALUE(FILL), .CLEAR_ON_RESET(1'b0)) u_dut_b (
        .clock(clock), .reset(reset_b), .clear(clear), .busy(busy_b),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0_b), .gnt1(gnt1_b), .rvalid0(rvalid0_b), .rvalid1(rvalid1_b),
        .rdata(rdata_b), .ram_address(ram_address_b), .ram_data(ram_data_b),
        .ram_wren(ram_wren_b), .ram_q(ram_q_b), .conflict_cnt(conflict_cnt_b)
    );

    // Single-port RAMs: registered address/data/wren, unregistered read output
    logic [3:0] mem_a [32];
    logic [3:0] mem_b [32];
    logic [4:0] raq_a, raq_b;

    always @(posedge clock) begin
        if (ram_wren_a) mem_a[ram_address_a] <= ram_data_a;
        raq_a <= ram_address_a;
        if (ram_wren_b) mem_b[ram_address_b] <= ram_data_b;
        raq_b <= ram_address_b;
    end

    assign ram_q_a = mem_a[raq_a];
    assign ram_q_b = mem_b[raq_b];

    function automatic logic [1:0] model_grant(input logic r0, input logic r1);
        if (r0 && r1) return rr_pref ? 2'b01 : 2'b10;
        return {r0, r1};
    endfunction

    task automatic model_commit(input logic [1:0] g);
        if (req0 && req1 && ref_conf < 255) ref_conf++;
        exp_rv = 2'b00;
        if (g == 2'b10) begin
            rr_pref = 1'b1;
            if (we0) ref_mem[addr0] = wdata0;
            else begin exp_rv = 2'b10; exp_rd = ref_mem[addr0]; end
        end else if (g == 2'b01) begin
            rr_pref = 1'b0;
            if (we1) ref_mem[addr1] = wdata1;
            else begin exp_rv = 2'b01; exp_rd = ref_mem[addr1]; end
        end
    endtask

    task automatic model_fill();
        for (int k = 0; k < 32; k++) ref_mem[k] = FILL;
        rr_pref  = 1'b0;
        ref_conf = 0;
        exp_rv   = 2'b00;
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [4:0] a0, input logic [3:0] d0,
                         input logic r1, input logic w1, input logic [4:0] a1, input logic [3:0] d1);
        @(negedge clock);
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset_a = 1'b1; clear = 1'b0;
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        #1;
        checks++;
        if ({gnt0_a, gnt1_a, ram_wren_a} !== 3'b000) begin
            failures++;
            $display("FAIL reset_gnt got gnt0=%b gnt1=%b wren=%b exp 0 0 0", gnt0_a, gnt1_a, ram_wren_a);
        end
        @(negedge clock);
        #1;
        checks++;
        if ({rvalid0_a, rvalid1_a, gnt0_a, gnt1_a, ram_wren_a} !== 5'b0 || conflict_cnt_a !== 8'h00) begin
            failures++;
            $display("FAIL reset_state got rv=%b%b gnt=%b%b wren=%b conf=%0d exp all 0",
                     rvalid0_a, rvalid1_a, gnt0_a, gnt1_a, ram_wren_a, conflict_cnt_a);
        end
        @(negedge clock);
        reset_a = 1'b0; req0 = 1'b0; req1 = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (i > 0) @(negedge clock);
            #1;
            checks++;
            if (busy_a !== 1'b1 || ram_wren_a !== 1'b1 || ram_address_a !== 5'(i) ||
                ram_data_a !== FILL || gnt0_a !== 1'b0 || gnt1_a !== 1'b0) begin
                failures++;
                $display("FAIL clear_sweep cyc=%0d got busy=%b wren=%b addr=%0d data=%h exp 1 1 %0d %h",
                         i, busy_a, ram_wren_a, ram_address_a, ram_data_a, i, FILL);
            end
        end
        @(negedge clock);
        #1;
        checks++;
        if (busy_a !== 1'b0 || ram_wren_a !== 1'b0) begin
            failures++;
            $display("FAIL busy_fall got busy=%b wren=%b exp 0 0", busy_a, ram_wren_a);
        end
        model_fill();
    endtask

    task automatic test_fill_read();
        for (int i = 0; i < 2; i++) begin
            if (i == 0) drive(1'b1, 1'b0, 5'd17, 4'h0, 1'b0, 1'b0, 5'd0, 4'h0);
            else        drive(1'b0, 1'b0, 5'd0,  4'h0, 1'b0, 1'b0, 5'd0, 4'h0);
            #1;
            checks++;
            if ({rvalid0_a, rvalid1_a} !== exp_rv) begin
                failures++;
                $display("FAIL fill_rvalid cyc=%0d got=%b exp=%b", i, {rvalid0_a, rvalid1_a}, exp_rv);
            end
            if (exp_rv != 2'b00) begin
                checks++;
                if (rdata_a !== FILL) begin
                    failures++;
                    $display("FAIL fill_rdata got=%h exp=%h", rdata_a, FILL);
                end
            end
            exp_g = model_grant(req0, req1);
            checks++;
            if ({gnt0_a, gnt1_a} !== exp_g) begin
                failures++;
                $display("FAIL fill_gnt cyc=%0d got=%b exp=%b", i, {gnt0_a, gnt1_a}, exp_g);
            end
            model_commit(exp_g);
        end
    endtask

    task automatic test_write_then_read();
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       drive(1'b1, 1'b1, 5'd3, 4'hA, 1'b0, 1'b0, 5'd0, 4'h0);
                1:       drive(1'b0, 1'b0, 5'd0, 4'h0, 1'b1, 1'b0, 5'd3, 4'h0);
                default: drive(1'b0, 1'b0, 5'd0, 4'h0, 1'b0, 1'b0, 5'd0, 4'h0);
            endcase
            #1;
            checks++;
            if ({rvalid0_a, rvalid1_a} !== exp_rv) begin
                failures++;
                $display("FAIL wtr_rvalid cyc=%0d got=%b exp=%b", i, {rvalid0_a, rvalid1_a}, exp_rv);
            end
            if (exp_rv != 2'b00) begin
                checks++;
                if (rdata_a !== exp_rd) begin
                    failures++;
                    $display("FAIL wtr_rdata got=%h exp=%h", rdata_a, exp_rd);
                end
            end
            exp_g = model_grant(req0, req1);
            checks++;
            if ({gnt0_a, gnt1_a} !== exp_g) begin
                failures++;
                $display("FAIL wtr_gnt cyc=%0d got=%b exp=%b", i, {gnt0_a, gnt1_a}, exp_g);
            end
            model_commit(exp_g);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 9; i++) begin
            if (i < 4)      drive(1'b1, 1'b1, 5'(i), 4'($urandom_range(0, 15)), 1'b0, 1'b0, 5'd0, 4'h0);
            else if (i < 8) drive(1'b0, 1'b0, 5'd0, 4'h0, 1'b1, 1'b0, 5'(i - 4), 4'h0);
            else            drive(1'b0, 1'b0, 5'd0, 4'h0, 1'b0, 1'b0, 5'd0, 4'h0);
            #1;
            checks++;
            if ({rvalid0_a, rvalid1_a} !== exp_rv) begin
                failures++;
                $display("FAIL b2b_rvalid cyc=%0d got=%b exp=%b", i, {rvalid0_a, rvalid1_a}, exp_rv);
            end
            if (exp_rv != 2'b00) begin
                checks++;
                if (rdata_a !== exp_rd) begin
                    failures++;
                    $display("FAIL b2b_rdata cyc=%0d got=%h exp=%h", i, rdata_a, exp_rd);
                end
            end
            exp_g = model_grant(req0, req1);
            checks++;
            if ({gnt0_a, gnt1_a} !== exp_g) begin
                failures++;
                $display("FAIL b2b_gnt cyc=%0d got=%b exp=%b", i, {gnt0_a, gnt1_a}, exp_g);
            end
            model_commit(exp_g);
        end
    endtask

    task automatic test_clear_cmd();
        drive(1'b1, 1'b0, 5'd9, 4'h0, 1'b0, 1'b0, 5'd0, 4'h0);
        clear = 1'b1;
        #1;
        checks++;
        if ({gnt0_a, gnt1_a, ram_wren_a, busy_a} !== 4'b0000) begin
            failures++;
            $display("FAIL clr_cmd got gnt=%b%b wren=%b busy=%b exp all 0", gnt0_a, gnt1_a, ram_wren_a, busy_a);
        end
        for (int i = 0; i < 32; i++) begin
            @(negedge clock);
            clear = (i == 5);
            #1;
            checks++;
            if (busy_a !== 1'b1 || ram_wren_a !== 1'b1 || ram_address_a !== 5'(i) || ram_data_a !== FILL ||
                gnt0_a !== 1'b0 || gnt1_a !== 1'b0 || rvalid0_a !== 1'b0 || rvalid1_a !== 1'b0) begin
                failures++;
                $display("FAIL clr_sweep cyc=%0d got busy=%b wren=%b addr=%0d gnt0=%b exp 1 1 %0d 0",
                         i, busy_a, ram_wren_a, ram_address_a, gnt0_a, i);
            end
        end
        @(negedge clock);
        clear = 1'b0;
        #1;
        checks++;
        if (busy_a !== 1'b0 || gnt0_a !== 1'b1) begin
            failures++;
            $display("FAIL clr_after got busy=%b gnt0=%b exp 0 1", busy_a, gnt0_a);
        end
        for (int k = 0; k < 32; k++) ref_mem[k] = FILL;
        model_commit(2'b10);
        drive(1'b0, 1'b0, 5'd0, 4'h0, 1'b0, 1'b0, 5'd0, 4'h0);
        #1;
        checks++;
        if ({rvalid0_a, rvalid1_a} !== exp_rv || rdata_a !== exp_rd) begin
            failures++;
            $display("FAIL clr_read got rv=%b data=%h exp rv=%b data=%h",
                     {rvalid0_a, rvalid1_a}, rdata_a, exp_rv, exp_rd);
        end
        model_commit(2'b00);
    endtask

    task automatic test_random();
        logic p0 = 1'b0, p1 = 1'b0, w0 = 1'b0, w1 = 1'b0;
        logic [4:0] a0 = '0, a1 = '0;
        logic [3:0] d0 = '0, d1 = '0;
        for (int i = 0; i < 301; i++) begin
            if (!p0 && $urandom_range(0, 3) != 0) begin
                p0 = 1'b1; w0 = 1'($urandom_range(0, 1));
                a0 = 5'($urandom_range(0, 31)); d0 = 4'($urandom_range(0, 15));
            end
            if (!p1 && $urandom_range(0, 3) != 0) begin
                p1 = 1'b1; w1 = 1'($urandom_range(0, 1));
                a1 = 5'($urandom_range(0, 31)); d1 = 4'($urandom_range(0, 15));
            end
            if (i == 300) begin p0 = 1'b0; p1 = 1'b0; end
            drive(p0, w0, a0, d0, p1, w1, a1, d1);
            #1;
            checks++;
            if ({rvalid0_a, rvalid1_a} !== exp_rv) begin
                failures++;
                $display("FAIL rnd_rvalid cyc=%0d got=%b exp=%b", i, {rvalid0_a, rvalid1_a}, exp_rv);
            end
            if (exp_rv != 2'b00) begin
                checks++;
                if (rdata_a !== exp_rd) begin
                    failures++;
                    $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", i, rdata_a, exp_rd);
                end
            end
            exp_g = model_grant(req0, req1);
            checks++;
            if ({gnt0_a, gnt1_a} !== exp_g ||
                ram_wren_a !== ((exp_g[1] && we0) || (exp_g[0] && we1))) begin
                failures++;
                $display("FAIL rnd_gnt cyc=%0d got gnt=%b wren=%b exp gnt=%b", i, {gnt0_a, gnt1_a},
                         ram_wren_a, exp_g);
            end
            model_commit(exp_g);
            if (exp_g[1]) p0 = 1'b0;
            if (exp_g[0]) p1 = 1'b0;
        end
        checks++;
`ifdef RAM32X4_ARB_STATS_EN
        if (conflict_cnt_a !== 8'(ref_conf)) begin
            failures++;
            $display("FAIL rnd_conflict got=%0d exp=%0d", conflict_cnt_a, ref_conf);
        end
`else
        if (conflict_cnt_a !== 8'h00) begin
            failures++;
            $display("FAIL rnd_conflict got=%0d exp=0", conflict_cnt_a);
        end
`endif
    endtask

    task automatic test_contention();
        logic [4:0] a0, a1;
        test_reset();
        a0 = 5'($urandom_range(0, 31));
        a1 = 5'($urandom_range(0, 31));
        for (int i = 0; i < 7; i++) begin
            if (i < 6) drive(1'b1, 1'b0, a0, 4'h0, 1'b1, 1'b0, a1, 4'h0);
            else       drive(1'b0, 1'b0, 5'd0, 4'h0, 1'b0, 1'b0, 5'd0, 4'h0);
            #1;
            checks++;
            if ({rvalid0_a, rvalid1_a} !== exp_rv || (exp_rv != 2'b00 && rdata_a !== exp_rd)) begin
                failures++;
                $display("FAIL cont_rvalid cyc=%0d got rv=%b data=%h exp rv=%b data=%h", i,
                         {rvalid0_a, rvalid1_a}, rdata_a, exp_rv, exp_rd);
            end
            if (i < 6) begin
                exp_g = model_grant(req0, req1);
                checks++;
                if ({gnt0_a, gnt1_a} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                    failures++;
                    $display("FAIL cont_alternate cyc=%0d got=%b exp=%b", i, {gnt0_a, gnt1_a},
                             (i % 2 == 0) ? 2'b10 : 2'b01);
                end
                model_commit(exp_g);
                if (exp_g[1]) a0 = 5'($urandom_range(0, 31));
                else          a1 = 5'($urandom_range(0, 31));
            end
        end
        checks++;
        if (conflict_cnt_a !== EXP_CONTENTION) begin
            failures++;
            $display("FAIL cont_count got=%0d exp=%0d", conflict_cnt_a, EXP_CONTENTION);
        end
    endtask

    task automatic test_reset_midclear();
        @(negedge clock);
        reset_a = 1'b1; reset_b = 1'b0; clear = 1'b0; req0 = 1'b0; req1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       drive(1'b1, 1'b1, 5'd20, 4'hC, 1'b0, 1'b0, 5'd0, 4'h0);
                1:       drive(1'b1, 1'b1, 5'd5,  4'h3, 1'b0, 1'b0, 5'd0, 4'h0);
                default: drive(1'b1, 1'b0, 5'd20, 4'h0, 1'b0, 1'b0, 5'd0, 4'h0);
            endcase
            #1;
            checks++;
            if ({gnt0_b, gnt1_b, busy_b} !== 3'b100) begin
                failures++;
                $display("FAIL mc_pre_gnt cyc=%0d got gnt=%b%b busy=%b exp 1 0 0", i, gnt0_b, gnt1_b, busy_b);
            end
        end
        drive(1'b0, 1'b0, 5'd0, 4'h0, 1'b0, 1'b0, 5'd0, 4'h0);
        clear = 1'b1;
        #1;
        checks++;
        if (rvalid0_b !== 1'b1 || rdata_b !== 4'hC || busy_b !== 1'b0) begin
            failures++;
            $display("FAIL mc_pre20 got rv0=%b data=%h busy=%b exp 1 c 0", rvalid0_b, rdata_b, busy_b);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            clear = 1'b0;
            #1;
            checks++;
            if (busy_b !== 1'b1 || ram_wren_b !== 1'b1 || ram_address_b !== 5'(i) || ram_data_b !== FILL) begin
                failures++;
                $display("FAIL mc_sweep cyc=%0d got busy=%b wren=%b addr=%0d exp 1 1 %0d",
                         i, busy_b, ram_wren_b, ram_address_b, i);
            end
        end
        @(negedge clock);
        reset_b = 1'b1; req0 = 1'b1; we0 = 1'b0; addr0 = 5'd20;
        #1;
        checks++;
        if ({gnt0_b, gnt1_b, ram_wren_b} !== 3'b000) begin
            failures++;
            $display("FAIL mc_hold got gnt=%b%b wren=%b exp 0 0 0", gnt0_b, gnt1_b, ram_wren_b);
        end
        @(negedge clock);
        #1;
        checks++;
        if ({rvalid0_b, rvalid1_b, gnt0_b, gnt1_b, ram_wren_b} !== 5'b0 || conflict_cnt_b !== 8'h00) begin
            failures++;
            $display("FAIL mc_reset got rv=%b%b gnt=%b%b wren=%b conf=%0d exp all 0",
                     rvalid0_b, rvalid1_b, gnt0_b, gnt1_b, ram_wren_b, conflict_cnt_b);
        end
        @(negedge clock);
        reset_b = 1'b0;
        #1;
        checks++;
        if (busy_b !== 1'b0 || gnt0_b !== 1'b1 || ram_address_b !== 5'd20 || ram_wren_b !== 1'b0) begin
            failures++;
            $display("FAIL mc_idle got busy=%b gnt0=%b addr=%0d wren=%b exp 0 1 20 0",
                     busy_b, gnt0_b, ram_address_b, ram_wren_b);
        end
        drive(1'b1, 1'b0, 5'd5, 4'h0, 1'b0, 1'b0, 5'd0, 4'h0);
        #1;
        checks++;
        if (gnt0_b !== 1'b1 || rvalid0_b !== 1'b1 || rdata_b !== 4'hC) begin
            failures++;
            $display("FAIL mc_post20 got gnt0=%b rv0=%b data=%h exp 1 1 c", gnt0_b, rvalid0_b, rdata_b);
        end
        drive(1'b0, 1'b0, 5'd0, 4'h0, 1'b0, 1'b0, 5'd0, 4'h0);
        #1;
        checks++;
        if (rvalid0_b !== 1'b1 || rdata_b !== FILL) begin
            failures++;
            $display("FAIL mc_post5 got rv0=%b data=%h exp 1 %h", rvalid0_b, rdata_b, FILL);
        end
        drive(1'b0, 1'b0, 5'd0, 4'h0, 1'b0, 1'b0, 5'd0, 4'h0);
        #1;
        checks++;
        if ({rvalid0_b, rvalid1_b} !== 2'b00) begin
            failures++;
            $display("FAIL mc_quiet got rv=%b%b exp 00", rvalid0_b, rvalid1_b);
        end
    endtask

    initial begin
        test_reset();
        test_fill_read();
        test_write_then_read();
        test_back_to_back();
        test_clear_cmd();
        test_random();
        test_contention();
        test_reset_midclear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
